// File: rtl/cdc_sync_2ff.sv
// Multi-stage flip-flop synchronizer into the clk_i domain, with registered
// per-bit rise/fall detection on the synchronized value.
module cdc_sync_2ff #(
    parameter int unsigned           DATA_WIDTH  = 1,
    parameter int unsigned           STAGES      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_sync_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o,
    output logic                  changed_o
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("cdc_sync_2ff: STAGES must be at least 2");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $error("cdc_sync_2ff: DATA_WIDTH must be at least 1");
        end
    endgenerate

    // Edge helpers; both operands are flops, so the results are glitch-free.
    function automatic logic [DATA_WIDTH-1:0] rise_of(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] prev
    );
        return cur & ~prev;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fall_of(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] prev
    );
        return ~cur & prev;
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [DATA_WIDTH-1:0] sync_r [STAGES];
    logic [DATA_WIDTH-1:0] prev_r;
    logic [DATA_WIDTH-1:0] rise_s;
    logic [DATA_WIDTH-1:0] fall_s;

    // Synchronizer chain: data_i lands directly in stage 0, stages feed only each other.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_r[k] <= RESET_VALUE;
            end
        end else begin
            sync_r[0] <= data_i;
            for (int unsigned k = 1; k < STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Edge history of the synchronized value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_r <= RESET_VALUE;
        end else begin
            prev_r <= sync_r[STAGES-1];
        end
    end

    // Per-bit edge decode from the last stage and its history.
    always_comb begin
        rise_s = {DATA_WIDTH{1'b0}};
        fall_s = {DATA_WIDTH{1'b0}};
        rise_s = rise_of(sync_r[STAGES-1], prev_r);
        fall_s = fall_of(sync_r[STAGES-1], prev_r);
    end

    assign data_sync_o = sync_r[STAGES-1];
    assign rise_o      = rise_s;
    assign fall_o      = fall_s;
    assign changed_o   = |(rise_s | fall_s);

endmodule

// File: tb/tb_cdc_sync_2ff.sv
// Self-checking bench for cdc_sync_2ff: a 1-bit/2-stage instance and a
// 4-bit/3-stage instance with a non-zero reset value, sharing clock and reset.
`timescale 1ns/100ps
module tb_cdc_sync_2ff;

    logic       clk;
    logic       rst_n;
    logic       d1_data, d1_sync, d1_rise, d1_fall, d1_chg;
    logic [3:0] d2_data, d2_sync, d2_rise, d2_fall;
    logic       d2_chg;

    int passed = 0;
    int total  = 0;

    logic       sb1 [$];
    logic [3:0] sb2 [$];

    cdc_sync_2ff #(.DATA_WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d1_data),
        .data_sync_o(d1_sync), .rise_o(d1_rise), .fall_o(d1_fall), .changed_o(d1_chg)
    );

    cdc_sync_2ff #(.DATA_WIDTH(4), .STAGES(3), .RESET_VALUE(4'hA)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_i(d2_data),
        .data_sync_o(d2_sync), .rise_o(d2_rise), .fall_o(d2_fall), .changed_o(d2_chg)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        d1_data = 1'b1;
        d2_data = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (d1_sync !== 1'b0) $display("FAIL reset_sync1 got %b want 0", d1_sync); else passed++;
            total++; if ({d1_rise, d1_fall} !== 2'b00) $display("FAIL reset_edges1 got %b want 00", {d1_rise, d1_fall}); else passed++;
            total++; if (d2_sync !== 4'hA) $display("FAIL reset_sync2 got %h want a", d2_sync); else passed++;
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (d1_sync !== 1'b1) $display("FAIL release_sync1 got %b want 1", d1_sync); else passed++;
        tick();
        total++; if (d2_sync !== 4'hF) $display("FAIL release_sync2 got %h want f", d2_sync); else passed++;
        // Drop reset between edges: outputs must clear without a clock edge.
        #0.5;
        rst_n = 1'b0;
        #0.5;
        total++; if (d1_sync !== 1'b0) $display("FAIL async_reset_sync1 got %b want 0", d1_sync); else passed++;
        total++; if (d1_chg !== 1'b0) $display("FAIL async_reset_chg1 got %b want 0", d1_chg); else passed++;
        total++; if (d2_sync !== 4'hA) $display("FAIL async_reset_sync2 got %h want a", d2_sync); else passed++;
        d1_data = 1'b0;
    endtask

    task automatic test_latency();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        #1;
        d1_data = 1'b1;
        tick();
        total++; if ({d1_sync, d1_rise} !== 2'b00) $display("FAIL latency_edge1 got %b want 00", {d1_sync, d1_rise}); else passed++;
        tick();
        total++; if ({d1_sync, d1_rise, d1_chg} !== 3'b111) $display("FAIL latency_edge2 got %b want 111", {d1_sync, d1_rise, d1_chg}); else passed++;
        tick();
        total++; if ({d1_sync, d1_rise, d1_chg} !== 3'b100) $display("FAIL latency_edge3 got %b want 100", {d1_sync, d1_rise, d1_chg}); else passed++;
    endtask

    task automatic test_random_stream();
        logic b;
        logic exp;
        for (int i = 0; i < 100; i++) begin
            tick();
            #(0.1 * $urandom_range(0, 10));
            b = 1'($urandom_range(0, 1));
            d1_data = b;
            sb1.push_back(b);
            tick(); tick(); tick();
            exp = sb1.pop_front();
            total++; if (d1_sync !== exp) $display("FAIL stream[%0d] got %b want %b", i, d1_sync, exp); else passed++;
        end
    endtask

    task automatic test_fall_and_reset();
        int falls;
        d1_data = 1'b0;
        repeat (4) tick();
        d1_data = 1'b1;
        tick();
        rst_n   = 1'b0;
        d1_data = 1'b0;
        #1;
        total++; if (d1_sync !== 1'b0) $display("FAIL midreset_sync got %b want 0", d1_sync); else passed++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({d1_sync, d1_rise} !== 2'b00) $display("FAIL after_release[%0d] got %b want 00", i, {d1_sync, d1_rise}); else passed++;
        end
        d1_data = 1'b1;
        repeat (4) tick();
        total++; if (d1_sync !== 1'b1) $display("FAIL pre_fall_sync got %b want 1", d1_sync); else passed++;
        d1_data = 1'b0;
        falls = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (d1_fall === 1'b1) falls++;
            if (i == 1) begin
                total++; if ({d1_sync, d1_fall, d1_chg} !== 3'b011) $display("FAIL fall_edge2 got %b want 011", {d1_sync, d1_fall, d1_chg}); else passed++;
            end
        end
        total++; if (falls !== 1) $display("FAIL fall_count got %0d want 1", falls); else passed++;
    endtask

    task automatic test_multibit();
        logic [3:0] gray [4];
        logic [3:0] prevm;
        logic [3:0] exp;
        gray[0] = 4'h0; gray[1] = 4'h1; gray[2] = 4'h3; gray[3] = 4'h2;
        rst_n = 1'b0;
        #1;
        total++; if (d2_sync !== 4'hA) $display("FAIL mb_reset got %h want a", d2_sync); else passed++;
        d2_data = 4'hA;
        rst_n   = 1'b1;
        prevm   = 4'hA;
        tick();
        for (int i = 0; i < 4; i++) begin
            d2_data = gray[i];
            sb2.push_back(gray[i]);
            tick(); tick();
            total++; if ({d2_sync, d2_chg} !== {prevm, 1'b0}) $display("FAIL mb_hold[%0d] got %h/%b want %h/0", i, d2_sync, d2_chg, prevm); else passed++;
            tick();
            exp = sb2.pop_front();
            total++; if (d2_sync !== exp) $display("FAIL mb_value[%0d] got %h want %h", i, d2_sync, exp); else passed++;
            total++; if (d2_rise !== (exp & ~prevm)) $display("FAIL mb_rise[%0d] got %b want %b", i, d2_rise, exp & ~prevm); else passed++;
            total++; if (d2_fall !== (~exp & prevm)) $display("FAIL mb_fall[%0d] got %b want %b", i, d2_fall, ~exp & prevm); else passed++;
            prevm = exp;
            tick();
            total++; if ({d2_rise, d2_fall} !== 8'h00) $display("FAIL mb_pulse_end[%0d] got %h want 00", i, {d2_rise, d2_fall}); else passed++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        d1_data = 1'b0;
        d2_data = 4'h0;
        test_reset();
        test_latency();
        test_random_stream();
        test_fall_and_reset();
        test_multibit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
